// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: two-flop synchroniser, bit-timing FSM and a one-byte
// holding register with an active-low valid/ready handshake.
module uart_rx_deser #(
    parameter int UART_CDIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] data_out,
    output logic       valid_n,
    input  logic       ready_n,
    output logic       framing_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = UART_CDIV / 2;
    localparam int DW   = (UART_CDIV > 2) ? $clog2(UART_CDIV) : 1;

    localparam logic [DW-1:0] DIV_FULL = DW'(UART_CDIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(HALF - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAITHI
    } state_t;

    state_t         r_state;
    logic           r_sync1;
    logic           r_rxs;
    logic [DW-1:0]  r_div;
    logic [2:0]     r_bit;
    logic [7:0]     r_shift;
    logic [7:0]     r_data;
    logic           r_valid_n;
    logic           r_fe;
    logic           r_ov;

    logic           w_xfer;
    logic           w_tick;

    assign w_xfer = !r_valid_n && !ready_n;
    assign w_tick = (r_div == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sync1   <= 1'b1;
            r_rxs     <= 1'b1;
            r_div     <= '0;
            r_bit     <= 3'd0;
            r_shift   <= 8'h00;
            r_data    <= 8'h00;
            r_valid_n <= 1'b1;
            r_fe      <= 1'b0;
            r_ov      <= 1'b0;
        end else begin
            r_sync1 <= uart_rx;
            r_rxs   <= r_sync1;
            r_fe    <= 1'b0;
            r_ov    <= 1'b0;
            if (w_xfer) begin
                r_valid_n <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        r_state <= S_START;
                        r_div   <= DIV_HALF;
                    end
                end
                S_START: begin
                    if (!w_tick) begin
                        r_div <= r_div - DIV_ONE;
                    end else if (!r_rxs) begin
                        r_state <= S_DATA;
                        r_div   <= DIV_FULL;
                        r_bit   <= 3'd0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (!w_tick) begin
                        r_div <= r_div - DIV_ONE;
                    end else begin
                        r_shift <= {r_rxs, r_shift[7:1]};
                        r_div   <= DIV_FULL;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (!w_tick) begin
                        r_div <= r_div - DIV_ONE;
                    end else if (r_rxs) begin
                        // Straight to IDLE so a start bit right after the stop is seen.
                        r_state <= S_IDLE;
                        if (r_valid_n || w_xfer) begin
                            r_data    <= r_shift;
                            r_valid_n <= 1'b0;
                        end else begin
                            r_ov <= 1'b1;
                        end
                    end else begin
                        r_fe    <= 1'b1;
                        r_state <= S_WAITHI;
                    end
                end
                S_WAITHI: begin
                    if (r_rxs) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_out    = r_data;
    assign valid_n     = r_valid_n;
    assign framing_err = r_fe;
    assign overrun     = r_ov;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: one instance at 2 cycles/bit and one
// at 4 cycles/bit, driven with hand-built 8N1 frames.
module tb_uart_rx_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx4;
    logic       rdy_n;
    logic       rdy4_n;
    logic [7:0] dout;
    logic [7:0] dout4;
    logic       vn;
    logic       vn4;
    logic       fe;
    logic       fe4;
    logic       ov;
    logic       ov4;
    logic       bsy;
    logic       bsy4;

    int n_chk = 0;
    int n_bad = 0;
    int n_fe  = 0;
    int n_ov  = 0;
    int n_fe4 = 0;
    logic [7:0] got_q[$];

    int lat;
    int base;
    int fe0;
    int ov0;

    uart_rx_deser #(.UART_CDIV(2)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (rx),
        .data_out    (dout),
        .valid_n     (vn),
        .ready_n     (rdy_n),
        .framing_err (fe),
        .overrun     (ov),
        .busy        (bsy)
    );

    uart_rx_deser #(.UART_CDIV(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .uart_rx     (rx4),
        .data_out    (dout4),
        .valid_n     (vn4),
        .ready_n     (rdy4_n),
        .framing_err (fe4),
        .overrun     (ov4),
        .busy        (bsy4)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (fe)  n_fe++;
            if (ov)  n_ov++;
            if (fe4) n_fe4++;
            if (!vn && !rdy_n) got_q.push_back(dout);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stp,
                        input bit sel, input int cdiv);
        logic [9:0] f;
        f = {stp, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (sel) rx4 = f[i];
            else     rx  = f[i];
            repeat (cdiv) step();
        end
    endtask

    task automatic wait_v(input bit sel, input int budget, output int l);
        l = 0;
        while (l < budget && (sel ? vn4 : vn)) begin
            step();
            l++;
        end
    endtask

    task automatic consume();
        rdy_n = 1'b0;
        step();
        rdy_n = 1'b1;
    endtask

    initial begin
        rst    = 1'b1;
        rx     = 1'b1;
        rx4    = 1'b1;
        rdy_n  = 1'b1;
        rdy4_n = 1'b1;
        repeat (3) step();
        chk("rst_data", dout, 8'h00);
        chk("rst_vn", vn, 1'b1);
        chk("rst_busy", bsy, 1'b0);
        chk("rst_fe", fe, 1'b0);
        chk("rst_ov", ov, 1'b0);
        chk("rst_vn4", vn4, 1'b1);
        rst = 1'b0;
        repeat (4) step();

        // single byte, latency and hold
        fork
            send(8'h61, 1'b1, 1'b0, 2);
            wait_v(1'b0, 40, lat);
        join
        chk("t1_lat", lat, 22);
        chk("t1_data", dout, 8'h61);
        repeat (10) step();
        chk("t1_hold_vn", vn, 1'b0);
        chk("t1_hold_data", dout, 8'h61);
        chk("t1_fe", n_fe, 0);
        chk("t1_ov", n_ov, 0);
        chk("t1_idle", bsy, 1'b0);

        // consume then next byte
        consume();
        chk("t2_consumed", vn, 1'b1);
        fork
            send(8'h62, 1'b1, 1'b0, 2);
            wait_v(1'b0, 40, lat);
        join
        chk("t2_data", dout, 8'h62);
        chk("t2_vn", vn, 1'b0);
        consume();
        repeat (2) step();

        // glitch at 4 cycles/bit
        rx4 = 1'b0;
        step();
        rx4 = 1'b1;
        lat = 0;
        while (!bsy4 && lat < 10) begin
            step();
            lat++;
        end
        chk("t3_rise", lat, 2);
        lat = 0;
        while (bsy4 && lat < 10) begin
            step();
            lat++;
        end
        chk("t3_fall", lat, 2);
        repeat (5) step();
        chk("t3_vn", vn4, 1'b1);
        chk("t3_fe", n_fe4, 0);
        fork
            send(8'h61, 1'b1, 1'b1, 4);
            wait_v(1'b1, 60, lat);
        join
        chk("t3_lat4", lat, 41);
        chk("t3_data4", dout4, 8'h61);

        // framing error followed by break
        fe0 = n_fe;
        send(8'h41, 1'b0, 1'b0, 2);
        repeat (10) step();
        chk("t4_busy", bsy, 1'b1);
        chk("t4_fe", n_fe - fe0, 1);
        chk("t4_vn", vn, 1'b1);
        rx = 1'b1;
        repeat (5) step();
        chk("t4_idle", bsy, 1'b0);
        chk("t4_fe_once", n_fe - fe0, 1);
        fork
            send(8'h63, 1'b1, 1'b0, 2);
            wait_v(1'b0, 40, lat);
        join
        chk("t4_c", dout, 8'h63);
        consume();
        repeat (2) step();

        // back-to-back with stalled consumer
        ov0 = n_ov;
        send(8'h61, 1'b1, 1'b0, 2);
        send(8'h62, 1'b1, 1'b0, 2);
        send(8'h63, 1'b1, 1'b0, 2);
        repeat (10) step();
        chk("t5_ov", n_ov - ov0, 2);
        chk("t5_data", dout, 8'h61);
        chk("t5_vn", vn, 1'b0);
        consume();

        // back-to-back with open consumer
        base = got_q.size();
        ov0  = n_ov;
        rdy_n = 1'b0;
        send(8'h61, 1'b1, 1'b0, 2);
        send(8'h62, 1'b1, 1'b0, 2);
        send(8'h63, 1'b1, 1'b0, 2);
        repeat (10) step();
        rdy_n = 1'b1;
        chk("t5_cnt", got_q.size() - base, 3);
        chk("t5_b0", got_q[base], 8'h61);
        chk("t5_b1", got_q[base+1], 8'h62);
        chk("t5_b2", got_q[base+2], 8'h63);
        chk("t5_ov2", n_ov - ov0, 0);
        chk("t5_vn2", vn, 1'b1);

        // reset mid-frame with a byte held
        fork
            send(8'h61, 1'b1, 1'b0, 2);
            wait_v(1'b0, 40, lat);
        join
        chk("t6_pre", vn, 1'b0);
        fork
            send(8'h64, 1'b1, 1'b0, 2);
            begin
                repeat (10) step();
                rst = 1'b1;
                step();
                chk("t6_rdata", dout, 8'h00);
                chk("t6_rvn", vn, 1'b1);
                chk("t6_rbusy", bsy, 1'b0);
                chk("t6_rfe", fe, 1'b0);
                repeat (10) step();
                rst = 1'b0;
            end
        join
        repeat (8) step();
        chk("t6_vn", vn, 1'b1);
        chk("t6_busy", bsy, 1'b0);
        fork
            send(8'h65, 1'b1, 1'b0, 2);
            wait_v(1'b0, 40, lat);
        join
        chk("t6_e", dout, 8'h65);
        chk("t6_e_vn", vn, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
